// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps MIDI note events onto a bank of
// oscillator voices, retriggering, filling free slots or stealing the oldest.
module voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int IDX_BW     = $clog2(NUM_VOICES)
) (
  input  logic                    clk_i,
  input  logic                    nrst_i,
  input  logic                    evValid_i,
  output logic                    evReady_o,
  input  logic                    evNoteOn_i,
  input  logic [7:0]              evNote_i,
  input  logic [6:0]              evVel_i,
  input  logic                    panic_i,
  output logic [8*NUM_VOICES-1:0] voiceNote_o,
  output logic [NUM_VOICES-1:0]   voiceEn_o,
  output logic [NUM_VOICES-1:0]   voicePhaseRst_o,
  output logic                    steal_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_APPLY = 2'd2;

  localparam logic [IDX_BW-1:0] LAST = IDX_BW'(NUM_VOICES - 1);

  logic [1:0]        state_q;
  logic [IDX_BW-1:0] idx_q;
  logic [7:0]        ev_note_q;
  logic              ev_on_q;

  logic              match_vld_q;
  logic              free_vld_q;
  logic              old_vld_q;
  logic [IDX_BW-1:0] match_idx_q;
  logic [IDX_BW-1:0] free_idx_q;
  logic [IDX_BW-1:0] old_idx_q;
  logic [IDX_BW-1:0] old_age_q;

  logic [NUM_VOICES-1:0][7:0]        note_q;
  logic [NUM_VOICES-1:0][IDX_BW-1:0] age_q;
  logic [NUM_VOICES-1:0]             en_q;
  logic [NUM_VOICES-1:0]             prst_q;
  logic                              steal_q;

  logic              accept;
  logic [IDX_BW-1:0] tgt;

  assign evReady_o       = (state_q == S_IDLE) && !panic_i;
  assign accept          = evValid_i && evReady_o;
  assign voiceNote_o     = note_q;
  assign voiceEn_o       = en_q;
  assign voicePhaseRst_o = prst_q;
  assign steal_o         = steal_q;

  // Retrigger beats free slot, free slot beats stealing.
  always_comb begin
    tgt = old_idx_q;
    if (match_vld_q) begin
      tgt = match_idx_q;
    end else if (free_vld_q) begin
      tgt = free_idx_q;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ev_note_q   <= '0;
      ev_on_q     <= 1'b0;
      match_vld_q <= 1'b0;
      free_vld_q  <= 1'b0;
      old_vld_q   <= 1'b0;
      match_idx_q <= '0;
      free_idx_q  <= '0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
      note_q      <= '0;
      age_q       <= '0;
      en_q        <= '0;
      prst_q      <= '0;
      steal_q     <= 1'b0;
    end else begin
      prst_q  <= '0;
      steal_q <= 1'b0;
      if (panic_i) begin
        state_q <= S_IDLE;
        en_q    <= '0;
        age_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              ev_note_q   <= evNote_i;
              ev_on_q     <= evNoteOn_i && (evVel_i != 7'd0);
              match_vld_q <= 1'b0;
              free_vld_q  <= 1'b0;
              old_vld_q   <= 1'b0;
              match_idx_q <= '0;
              free_idx_q  <= '0;
              old_idx_q   <= '0;
              old_age_q   <= '0;
              idx_q       <= '0;
              state_q     <= S_SCAN;
            end
          end
          S_SCAN: begin
            if (en_q[idx_q]) begin
              if (!match_vld_q && note_q[idx_q] == ev_note_q) begin
                match_vld_q <= 1'b1;
                match_idx_q <= idx_q;
              end
              if (!old_vld_q || age_q[idx_q] > old_age_q) begin
                old_vld_q <= 1'b1;
                old_idx_q <= idx_q;
                old_age_q <= age_q[idx_q];
              end
            end else if (!free_vld_q) begin
              free_vld_q <= 1'b1;
              free_idx_q <= idx_q;
            end
            idx_q <= idx_q + 1'b1;
            if (idx_q == LAST) begin
              state_q <= S_APPLY;
            end
          end
          S_APPLY: begin
            state_q <= S_IDLE;
            if (ev_on_q) begin
              for (int k = 0; k < NUM_VOICES; k++) begin
                if (en_q[k] && IDX_BW'(k) != tgt && age_q[k] != LAST) begin
                  age_q[k] <= age_q[k] + 1'b1;
                end
              end
              en_q[tgt]   <= 1'b1;
              prst_q[tgt] <= 1'b1;
              age_q[tgt]  <= '0;
              if (!match_vld_q) begin
                note_q[tgt] <= ev_note_q;
              end
              steal_q <= !match_vld_q && !free_vld_q;
            end else if (match_vld_q) begin
              en_q[match_idx_q]  <= 1'b0;
              age_q[match_idx_q] <= '0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Randomized and directed bench for voice_alloc against an
// event-level allocation model.
module tb_voice_alloc;

  localparam int NV = 4;

  logic            clk_i = 1'b0;
  logic            nrst_i;
  logic            evValid_i;
  logic            evReady_o;
  logic            evNoteOn_i;
  logic [7:0]      evNote_i;
  logic [6:0]      evVel_i;
  logic            panic_i;
  logic [8*NV-1:0] voiceNote_o;
  logic [NV-1:0]   voiceEn_o;
  logic [NV-1:0]   voicePhaseRst_o;
  logic            steal_o;

  always #5 clk_i = ~clk_i;

  voice_alloc #(.NUM_VOICES(NV)) dut (
    .clk_i          (clk_i),
    .nrst_i         (nrst_i),
    .evValid_i      (evValid_i),
    .evReady_o      (evReady_o),
    .evNoteOn_i     (evNoteOn_i),
    .evNote_i       (evNote_i),
    .evVel_i        (evVel_i),
    .panic_i        (panic_i),
    .voiceNote_o    (voiceNote_o),
    .voiceEn_o      (voiceEn_o),
    .voicePhaseRst_o(voicePhaseRst_o),
    .steal_o        (steal_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // model: voice table with ages as the allocation rules define them
  bit         m_en[NV];
  logic [7:0] m_note[NV];
  int         m_age[NV];
  logic [NV-1:0] x_prst;
  bit            x_steal;

  function automatic logic [NV-1:0] m_en_vec();
    logic [NV-1:0] v;
    for (int k = 0; k < NV; k++) v[k] = m_en[k];
    return v;
  endfunction

  function automatic logic [8*NV-1:0] m_note_vec();
    logic [8*NV-1:0] v;
    for (int k = 0; k < NV; k++) v[8*k +: 8] = m_note[k];
    return v;
  endfunction

  task automatic m_panic();
    for (int k = 0; k < NV; k++) begin
      m_en[k]  = 1'b0;
      m_age[k] = 0;
    end
  endtask

  task automatic m_reset();
    m_panic();
    for (int k = 0; k < NV; k++) m_note[k] = 8'd0;
  endtask

  task automatic m_event(input bit on, input logic [7:0] n);
    int mi, fi, oi, t;
    mi = -1; fi = -1; oi = -1;
    for (int k = 0; k < NV; k++) begin
      if (m_en[k] && m_note[k] == n && mi < 0) mi = k;
      if (!m_en[k] && fi < 0) fi = k;
      if (m_en[k] && (oi < 0 || m_age[k] > m_age[oi])) oi = k;
    end
    x_prst  = '0;
    x_steal = 1'b0;
    if (on) begin
      t = (mi >= 0) ? mi : (fi >= 0) ? fi : oi;
      for (int k = 0; k < NV; k++)
        if (m_en[k] && k != t)
          m_age[k] = (m_age[k] + 1 > NV - 1) ? NV - 1 : m_age[k] + 1;
      if (mi < 0) m_note[t] = n;
      m_en[t]  = 1'b1;
      m_age[t] = 0;
      x_prst[t] = 1'b1;
      x_steal  = (mi < 0 && fi < 0);
    end else if (mi >= 0) begin
      m_en[mi] = 1'b0;
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_en"},   64'(voiceEn_o),   64'(m_en_vec()));
    chk({tag, "_note"}, 64'(voiceNote_o), 64'(m_note_vec()));
  endtask

  // called at a negedge; returns at a negedge
  task automatic run_ev(input bit on, input logic [7:0] n, input logic [6:0] vel);
    logic [NV-1:0] pre_en;
    int w;
    w = 0;
    while (!evReady_o && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    if (!evReady_o) begin
      chk("ready_timeout", 64'(evReady_o), 64'd1);
      return;
    end
    evValid_i  = 1'b1;
    evNoteOn_i = on;
    evNote_i   = n;
    evVel_i    = vel;
    @(posedge clk_i);
    #1;
    evValid_i  = 1'b0;
    evNoteOn_i = 1'($urandom);
    evNote_i   = 8'($urandom);
    evVel_i    = 7'($urandom);
    chk("busy", 64'(evReady_o), 64'd0);
    pre_en = m_en_vec();
    m_event(on && vel != 7'd0, n);
    repeat (NV) @(posedge clk_i);
    #1;
    chk("early_en", 64'(voiceEn_o), 64'(pre_en));
    @(posedge clk_i);
    #1;
    chk_outs("apply");
    chk("prst", 64'(voicePhaseRst_o), 64'(x_prst));
    chk("steal", 64'(steal_o), 64'(x_steal));
    chk("ready_back", 64'(evReady_o), 64'd1);
    @(posedge clk_i);
    #1;
    chk("prst_end", 64'(voicePhaseRst_o), 64'd0);
    chk("steal_end", 64'(steal_o), 64'd0);
    @(negedge clk_i);
  endtask

  task automatic panic_pulse();
    panic_i = 1'b1;
    #1;
    chk("panic_rdy", 64'(evReady_o), 64'd0);
    @(posedge clk_i);
    #1;
    m_panic();
    chk_outs("panic");
    chk("panic_prst", 64'(voicePhaseRst_o), 64'd0);
    @(negedge clk_i);
    panic_i = 1'b0;
  endtask

  task automatic do_reset();
    nrst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    m_reset();
    chk_outs("rst");
    chk("rst_rdy", 64'(evReady_o), 64'd1);
    chk("rst_prst", 64'(voicePhaseRst_o), 64'd0);
    chk("rst_steal", 64'(steal_o), 64'd0);
    nrst_i = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    evValid_i  = 1'b0;
    evNoteOn_i = 1'b0;
    evNote_i   = 8'd0;
    evVel_i    = 7'd0;
    panic_i    = 1'b0;
    m_reset();
    do_reset();

    // fill four voices then steal the oldest
    run_ev(1'b1, 8'd60, 7'd100);
    run_ev(1'b1, 8'd64, 7'd90);
    run_ev(1'b1, 8'd67, 7'd80);
    run_ev(1'b1, 8'd72, 7'd70);
    run_ev(1'b1, 8'd76, 7'd60);
    chk("steal_v0", 64'(voiceNote_o[7:0]), 64'd76);
    panic_pulse();

    // retrigger
    run_ev(1'b1, 8'd60, 7'd100);
    run_ev(1'b1, 8'd60, 7'd100);
    panic_pulse();

    // note-off variants
    run_ev(1'b1, 8'd60, 7'd100);
    run_ev(1'b1, 8'd64, 7'd100);
    run_ev(1'b0, 8'd60, 7'd64);
    run_ev(1'b1, 8'd64, 7'd0);
    run_ev(1'b0, 8'd70, 7'd64);

    // panic while scanning a new note-on
    run_ev(1'b1, 8'd60, 7'd100);
    run_ev(1'b1, 8'd64, 7'd100);
    run_ev(1'b1, 8'd67, 7'd100);
    evValid_i = 1'b1; evNoteOn_i = 1'b1; evNote_i = 8'd72; evVel_i = 7'd99;
    @(posedge clk_i);
    #1;
    evNote_i = 8'd74;
    @(negedge clk_i);
    panic_pulse();
    evValid_i = 1'b0;
    #1;
    chk("panic_idle_rdy", 64'(evReady_o), 64'd1);
    repeat (NV + 2) @(posedge clk_i);
    #1;
    chk_outs("panic_drop");
    @(negedge clk_i);

    // reset during APPLY
    run_ev(1'b1, 8'd50, 7'd100);
    evValid_i = 1'b1; evNoteOn_i = 1'b1; evNote_i = 8'd80; evVel_i = 7'd50;
    @(posedge clk_i);
    #1;
    evValid_i = 1'b0;
    repeat (NV) @(posedge clk_i);
    #1;
    nrst_i = 1'b0;
    #1;
    m_reset();
    chk_outs("rst_apply");
    chk("rst_apply_prst", 64'(voicePhaseRst_o), 64'd0);
    chk("rst_apply_rdy", 64'(evReady_o), 64'd1);
    @(negedge clk_i);
    nrst_i = 1'b1;
    repeat (NV + 2) @(posedge clk_i);
    #1;
    chk_outs("rst_abort");
    chk("rst_abort_rdy", 64'(evReady_o), 64'd1);
    @(negedge clk_i);

    // random traffic
    for (int i = 0; i < 250; i++) begin
      logic [7:0] n;
      logic [6:0] v;
      if ($urandom_range(0, 19) == 0) begin
        panic_pulse();
      end else begin
        n = 8'(60 + $urandom_range(0, 7));
        if ($urandom_range(0, 4) == 0) n = n | 8'h80;
        v = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
        run_ev($urandom_range(0, 2) != 0, n, v);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
